// File: rtl/awg_cmd_pkg.sv
// Shared constants and helpers for the AWG ASCII command controller.
// Holds opcode characters, digit counts, range limits, reset values and FSM states.
package awg_cmd_pkg;

  localparam logic [7:0] ASCII_W = 8'h77;
  localparam logic [7:0] ASCII_F = 8'h66;
  localparam logic [7:0] ASCII_A = 8'h61;
  localparam logic [7:0] ASCII_P = 8'h70;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  localparam logic [2:0] DIGITS_W = 3'd1;
  localparam logic [2:0] DIGITS_F = 3'd4;
  localparam logic [2:0] DIGITS_A = 3'd1;
  localparam logic [2:0] DIGITS_P = 3'd3;

  localparam logic [13:0] W_MAX = 14'd4;
  localparam logic [13:0] F_MIN = 14'd1;
  localparam logic [13:0] F_MAX = 14'd4095;
  localparam logic [13:0] A_MIN = 14'd1;
  localparam logic [13:0] A_MAX = 14'd7;
  localparam logic [13:0] P_MAX = 14'd255;

  localparam logic [2:0] RST_WAVE  = 3'd0;
  localparam logic [2:0] RST_AMP   = 3'd2;
  localparam logic [7:0] RST_PHASE = 8'd50;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_W = 2'd0,
    OP_F = 2'd1,
    OP_A = 2'd2,
    OP_P = 2'd3
  } op_e;

  function automatic logic is_opcode(input logic [7:0] c);
    return (c == ASCII_W) || (c == ASCII_F) || (c == ASCII_A) || (c == ASCII_P);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

  function automatic op_e decode_op(input logic [7:0] c);
    op_e op;
    case (c)
      ASCII_F: op = OP_F;
      ASCII_A: op = OP_A;
      ASCII_P: op = OP_P;
      default: op = OP_W;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] digits_for(input op_e op);
    logic [2:0] n;
    case (op)
      OP_F:    n = DIGITS_F;
      OP_A:    n = DIGITS_A;
      OP_P:    n = DIGITS_P;
      default: n = DIGITS_W;
    endcase
    return n;
  endfunction

  function automatic logic in_range(input op_e op, input logic [13:0] v);
    logic ok;
    case (op)
      OP_F:    ok = (v >= F_MIN) && (v <= F_MAX);
      OP_A:    ok = (v >= A_MIN) && (v <= A_MAX);
      OP_P:    ok = (v <= P_MAX);
      default: ok = (v <= W_MAX);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: acc = acc*10 + digit, with a digit counter.
// done flags the digit being accepted this cycle as the last one of the command.
module dec_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [3:0]  digit,
  input  logic [2:0]  target,
  output logic [13:0] acc_next,
  output logic        done
);

  logic [13:0] acc_reg;
  logic [2:0]  cnt_reg;

  // x*10 as (x<<3)+(x<<1); four digits never exceed 9999, so 14 bits suffice
  always_comb begin
    acc_next = (acc_reg << 3) + (acc_reg << 1) + {10'd0, digit};
    done     = en && ((cnt_reg + 3'd1) == target);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

endmodule

// File: rtl/awg_cmd_ctrl.sv
// ASCII command parser driving the waveform generator configuration registers.
// Accepts w/f/a/p opcodes followed by fixed-length decimal arguments.
module awg_cmd_ctrl
  import awg_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int RST_FREQ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [2:0]  wave_sel,
  output logic [11:0] freq_word,
  output logic [2:0]  amp_sel,
  output logic [7:0]  phase_off,
  output logic        cfg_update,
  output logic        cmd_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e          state_reg;
  op_e             op_reg;
  logic [CNT_W-1:0] idle_cnt_reg;
  logic [2:0]      wave_sel_reg;
  logic [11:0]     freq_word_reg;
  logic [2:0]      amp_sel_reg;
  logic [7:0]      phase_off_reg;
  logic            cfg_update_reg;
  logic            cmd_err_reg;

  logic        rx_is_digit;
  logic        op_start;
  logic        acc_en;
  logic        acc_done;
  logic [13:0] acc_next;
  logic [2:0]  target;

  always_comb begin
    rx_is_digit = is_digit(rx_data);
    op_start    = rx_valid && (state_reg == ST_IDLE) && is_opcode(rx_data);
    acc_en      = rx_valid && (state_reg == ST_COLLECT) && rx_is_digit;
    target      = digits_for(op_reg);
  end

  dec_accum u_dec_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (op_start),
    .en       (acc_en),
    .digit    (rx_data[3:0]),
    .target   (target),
    .acc_next (acc_next),
    .done     (acc_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_W;
      idle_cnt_reg   <= '0;
      wave_sel_reg   <= RST_WAVE;
      freq_word_reg  <= 12'(RST_FREQ);
      amp_sel_reg    <= RST_AMP;
      phase_off_reg  <= RST_PHASE;
      cfg_update_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      cfg_update_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (op_start) begin
            op_reg       <= decode_op(rx_data);
            idle_cnt_reg <= '0;
            state_reg    <= ST_COLLECT;
          end
        end
        default: begin
          if (rx_valid) begin
            // A character arriving on the timeout cycle takes precedence
            idle_cnt_reg <= '0;
            if (!rx_is_digit) begin
              cmd_err_reg <= 1'b1;
              state_reg   <= ST_IDLE;
            end else if (acc_done) begin
              state_reg <= ST_IDLE;
              if (in_range(op_reg, acc_next)) begin
                cfg_update_reg <= 1'b1;
                case (op_reg)
                  OP_F:    freq_word_reg <= acc_next[11:0];
                  OP_A:    amp_sel_reg   <= acc_next[2:0];
                  OP_P:    phase_off_reg <= acc_next[7:0];
                  default: wave_sel_reg  <= acc_next[2:0];
                endcase
              end else begin
                cmd_err_reg <= 1'b1;
              end
            end
          end else if (idle_cnt_reg == IDLE_LAST) begin
            cmd_err_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    wave_sel   = wave_sel_reg;
    freq_word  = freq_word_reg;
    amp_sel    = amp_sel_reg;
    phase_off  = phase_off_reg;
    cfg_update = cfg_update_reg;
    cmd_err    = cmd_err_reg;
    busy       = (state_reg == ST_COLLECT);
  end

endmodule

// File: doc/awg_cmd_ctrl.md
AWG_CMD_CTRL -- requirements
Module: awg_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000000, is the maximum clk cycles allowed between characters of one command (1 s at 50 MHz).
REQ-002 Parameter RST_FREQ, default 1, is the freq_word value loaded at reset.
REQ-003 Port clk: input, 1 bit, single system clock; all logic is on its rising edge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port rx_data: input, 8 bits, received ASCII character.
REQ-006 Port rx_valid: input, 1 bit, one-cycle strobe in the clk domain qualifying rx_data.
REQ-007 Port wave_sel: output, 3 bits, waveform select for the generator.
REQ-008 Port freq_word: output, 12 bits, frequency setting.
REQ-009 Port amp_sel: output, 3 bits, amplitude step.
REQ-010 Port phase_off: output, 8 bits, phase offset.
REQ-011 Port cfg_update: output, 1 bit, one-cycle pulse marking a configuration change.
REQ-012 Port cmd_err: output, 1 bit, one-cycle pulse marking a rejected or aborted command.
REQ-013 Port busy: output, 1 bit, high while a command is partially received.

Function
REQ-014 Commands SHALL be a lowercase opcode followed by a fixed count of ASCII decimal digits: 'w' (0x77) + 1 digit; 'f' (0x66) + 4 digits; 'a' (0x61) + 1 digit; 'p' (0x70) + 3 digits.
REQ-015 FSM states SHALL be IDLE and COLLECT; busy SHALL equal (state == COLLECT).
REQ-016 In IDLE, a valid opcode SHALL latch the opcode, clear the accumulator and digit count, and move to COLLECT; any other character SHALL be ignored silently.
REQ-017 In COLLECT, each digit (0x30-0x39) SHALL update acc = acc*10 + (rx_data - 0x30), using a 14-bit accumulator.
REQ-018 In COLLECT, a non-digit character SHALL abort the command: pulse cmd_err, return to IDLE, discard the character, and leave outputs unchanged.
REQ-019 On the final digit, the new value SHALL be range-checked: w 0-4, f 1-4095, a 1-7, p 0-255.
REQ-020 An in-range final value SHALL be written to its output register on the same edge that samples the final digit; cfg_update SHALL be high during the following cycle; FSM returns to IDLE.
REQ-021 An out-of-range final value SHALL leave all outputs unchanged, pulse cmd_err for one cycle, and return the FSM to IDLE.
REQ-022 Only the register addressed by the opcode SHALL change; the other three SHALL hold.
REQ-023 In COLLECT, an idle counter SHALL count cycles without rx_valid; on reaching TIMEOUT_CYC it SHALL pulse cmd_err and return to IDLE.
REQ-024 If rx_valid coincides with the timeout cycle, the character SHALL win: it is processed and the counter clears.
REQ-025 cfg_update and cmd_err SHALL never be high in the same cycle.
REQ-026 A new command SHALL be accepted on the first rx_valid after returning to IDLE, including the cycle in which cfg_update or cmd_err is high.

Reset
REQ-027 On rst, outputs SHALL load wave_sel=0, freq_word=RST_FREQ, amp_sel=2, phase_off=50, cfg_update=0, cmd_err=0, busy=0.
REQ-028 On rst, the FSM SHALL go to IDLE and the accumulator, digit count and idle counter SHALL clear.
REQ-029 A reset during COLLECT SHALL discard the partial command without pulsing cmd_err.
REQ-030 rst SHALL take priority over rx_valid in the same cycle.

Structure
REQ-031 Shared package awg_cmd_pkg SHALL hold the ASCII opcode constants, the digit counts per opcode, the range limits, the reset values and the FSM state enum.
REQ-032 One sub-module, dec_accum, SHALL hold the 14-bit multiply-by-10-and-add accumulator and digit counter, with clear, enable and done outputs.

Verification
REQ-033 Send "f1000" -> freq_word=1000 on the edge of '0'; one cfg_update pulse; wave_sel, amp_sel and phase_off unchanged.
REQ-034 Send "p300" -> cmd_err pulses once; phase_off stays 50; no cfg_update.
REQ-035 Send "f12x" -> cmd_err on 'x'; busy drops; then "w3" -> wave_sel=3.
REQ-036 With TIMEOUT_CYC=100, send "a" and then nothing for 100 cycles -> cmd_err at cycle 100; busy=0. In a second run, send '5' exactly on cycle 100 -> amp_sel=5 and no cmd_err.
REQ-037 Send "f40" then assert rst -> all reset values restored; no cmd_err; then "f4095" -> freq_word=4095.
REQ-038 Send "Q7w2" -> 'Q' and '7' ignored in IDLE; wave_sel=2; one cfg_update pulse.
